// File: rtl/ntt_pkg.sv
// ntt_pkg: shared widths, FSM states and butterfly address mapping for the NTT layer sequencer.
package ntt_pkg;
    localparam int N = 256;
    localparam int NUM_BF = 128;
    localparam int ADDR_W = 8;
    localparam int TW_W = 7;
    localparam int LAYER_W = 3;
    localparam logic [LAYER_W-1:0] MAX_LAYER = 3'd6;
    localparam logic MODE_GS = 1'b0;
    localparam logic MODE_CT = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [TW_W-1:0]   tw;
    } bf_addr_t;

    // CT layers shrink the butterfly span as the layer grows; GS layers widen it.
    function automatic bf_addr_t bf_addr(input logic [6:0] k, input logic ct, input logic [LAYER_W-1:0] layer);
        logic [2:0] s;
        logic [ADDR_W-1:0] len, off, grp;
        bf_addr_t r;
        s = (ct == MODE_CT) ? 3'd7 - layer : layer + 3'd1;
        len = ADDR_W'(1) << s;
        off = {1'b0, k} & (len - 8'd1);
        grp = {1'b0, k} >> s;
        r.a = (grp << (4'(s) + 4'd1)) | off;
        r.b = r.a + len;
        r.tw = (ct == MODE_CT) ? TW_W'((8'd1 << layer) + grp) : TW_W'((8'd128 >> layer) - 8'd1 - grp);
        return r;
    endfunction
endpackage

// File: rtl/ntt_delay_line.sv
// ntt_delay_line: fixed-depth shift register with synchronous clear.
module ntt_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '{default: '0};
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/ntt_layer_sequencer.sv
// ntt_layer_sequencer: issues one NTT/INTT layer of butterfly reads and retimed write-backs.
module ntt_layer_sequencer
    import ntt_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ct,
    input  logic [LAYER_W-1:0] layer,
    output logic               busy,
    output logic               done,
    output logic               ct_mode,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr_a,
    output logic [ADDR_W-1:0]  rd_addr_b,
    output logic [TW_W-1:0]    tw_addr,
    output logic               bf_valid,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr_a,
    output logic [ADDR_W-1:0]  wr_addr_b
);
    localparam int LAT = RD_LAT + BF_LAT;
    localparam int DW = $clog2(LAT + 1);

    state_t state, state_d;
    logic [6:0] k, k_d;
    logic [DW-1:0] dcnt, dcnt_d;
    logic ct_d, issue_d;
    logic [LAYER_W-1:0] layer_r, layer_d;
    bf_addr_t nxt;

    always_comb begin
        state_d = state;
        k_d = k;
        dcnt_d = dcnt;
        ct_d = ct_mode;
        layer_d = layer_r;
        issue_d = 1'b0;
        case (state)
            S_IDLE: if (start && layer <= MAX_LAYER) begin
                state_d = S_ISSUE;
                k_d = '0;
                ct_d = ct;
                layer_d = layer;
                issue_d = 1'b1;
            end
            S_ISSUE: if (k == 7'(NUM_BF - 1)) begin
                state_d = S_DRAIN;
                dcnt_d = '0;
            end else begin
                k_d = k + 7'd1;
                issue_d = 1'b1;
            end
            // Wait out the read + butterfly pipeline so the last write lands before DONE.
            S_DRAIN: if (dcnt == DW'(LAT - 1)) state_d = S_DONE;
                     else dcnt_d = dcnt + 1'b1;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign nxt = bf_addr(k_d, ct_d, layer_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k <= '0;
            dcnt <= '0;
            ct_mode <= 1'b0;
            layer_r <= '0;
            rd_en <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr <= '0;
        end else begin
            state <= state_d;
            k <= k_d;
            dcnt <= dcnt_d;
            ct_mode <= ct_d;
            layer_r <= layer_d;
            rd_en <= issue_d;
            rd_addr_a <= nxt.a;
            rd_addr_b <= nxt.b;
            tw_addr <= nxt.tw;
        end
    end

    assign busy = (state == S_ISSUE) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    ntt_delay_line #(.DEPTH(LAT), .WIDTH(1 + 2 * ADDR_W)) u_wr_dly (
        .clk(clk),
        .rst(rst),
        .d({rd_en, rd_addr_a, rd_addr_b}),
        .q({wr_en, wr_addr_a, wr_addr_b})
    );

    ntt_delay_line #(.DEPTH(RD_LAT), .WIDTH(1)) u_bv_dly (
        .clk(clk),
        .rst(rst),
        .d(rd_en),
        .q(bf_valid)
    );
endmodule

// File: tb/tb_ntt_layer_sequencer.sv
// tb_ntt_layer_sequencer: directed layer runs against hand-computed addresses and timing.
module tb_ntt_layer_sequencer;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0, ct = 1'b0;
    logic [2:0] layer = 3'd0;
    logic busy, done, ct_mode, rd_en, bf_valid, wr_en;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_addr;
    logic busy2, done2, ct_mode2, rd_en2, bf_valid2, wr_en2;
    logic [7:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
    logic [6:0] tw_addr2;

    always #5 clk = ~clk;

    ntt_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .ct(ct), .layer(layer),
        .busy(busy), .done(done), .ct_mode(ct_mode), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .bf_valid(bf_valid), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    ntt_layer_sequencer #(.RD_LAT(2), .BF_LAT(6)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .ct(ct), .layer(layer),
        .busy(busy2), .done(done2), .ct_mode(ct_mode2), .rd_en(rd_en2),
        .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_addr(tw_addr2),
        .bf_valid(bf_valid2), .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2)
    );

    logic sel = 1'b0;
    logic m_busy, m_done, m_mode, m_rd, m_bv, m_wr;
    logic [7:0] m_ra, m_rb, m_wa, m_wb;
    logic [6:0] m_tw;
    assign m_busy = sel ? busy2 : busy;
    assign m_done = sel ? done2 : done;
    assign m_mode = sel ? ct_mode2 : ct_mode;
    assign m_rd = sel ? rd_en2 : rd_en;
    assign m_bv = sel ? bf_valid2 : bf_valid;
    assign m_wr = sel ? wr_en2 : wr_en;
    assign m_ra = sel ? rd_addr_a2 : rd_addr_a;
    assign m_rb = sel ? rd_addr_b2 : rd_addr_b;
    assign m_tw = sel ? tw_addr2 : tw_addr;
    assign m_wa = sel ? wr_addr_a2 : wr_addr_a;
    assign m_wb = sel ? wr_addr_b2 : wr_addr_b;

    typedef struct {
        bit ct;
        logic [2:0] layer;
        int k;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] tw;
    } vec_t;
    vec_t tab[$];

    int checks = 0, failures = 0;
    int rd_first, rd_last, rd_cnt, bv_first, bv_last, bv_cnt, wr_first, wr_last, wr_cnt;
    int busy_first, busy_last, busy_cnt, done_cyc, dup, wa0, wb0;
    logic [7:0] ra [128];
    logic [7:0] rb [128];
    logic [6:0] rt [128];
    bit seen [256];

    function automatic void chk(string n, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endfunction

    task automatic run(input bit s, input bit mode, input logic [2:0] lay, input int poke, input string tag);
        int rl, bl, mode_err, covered;
        rl = s ? 2 : 1;
        bl = s ? 6 : 4;
        rd_first = -1; rd_last = -1; rd_cnt = 0;
        bv_first = -1; bv_last = -1; bv_cnt = 0;
        wr_first = -1; wr_last = -1; wr_cnt = 0;
        busy_first = -1; busy_last = -1; busy_cnt = 0;
        done_cyc = -1; dup = 0; wa0 = -1; wb0 = -1; mode_err = 0; covered = 0;
        seen = '{default: 1'b0};
        sel = s;
        @(negedge clk);
        ct = mode;
        layer = lay;
        if (s) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start2 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (m_rd) begin
                if (rd_cnt < 128) begin
                    ra[rd_cnt] = m_ra;
                    rb[rd_cnt] = m_rb;
                    rt[rd_cnt] = m_tw;
                end
                if (rd_first < 0) rd_first = c;
                rd_last = c;
                rd_cnt++;
            end
            if (m_bv) begin
                if (bv_first < 0) bv_first = c;
                bv_last = c;
                bv_cnt++;
            end
            if (m_wr) begin
                if (wr_first < 0) begin
                    wr_first = c;
                    wa0 = int'(m_wa);
                    wb0 = int'(m_wb);
                end
                wr_last = c;
                wr_cnt++;
                if (seen[m_wa]) dup++;
                seen[m_wa] = 1'b1;
                if (seen[m_wb]) dup++;
                seen[m_wb] = 1'b1;
            end
            if (m_busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
                if (m_mode !== mode) mode_err++;
            end
            if (c == poke) begin
                start = 1'b1;
                ct = ~mode;
                layer = 3'd5;
            end else if (c == poke + 1) begin
                start = 1'b0;
            end
            if (m_done) begin
                done_cyc = c;
                break;
            end
        end
        for (int i = 0; i < 256; i++) if (seen[i]) covered++;
        chk({tag, " rd_first"}, rd_first, 1);
        chk({tag, " rd_last"}, rd_last, 128);
        chk({tag, " rd_cnt"}, rd_cnt, 128);
        chk({tag, " bv_first"}, bv_first, 1 + rl);
        chk({tag, " bv_last"}, bv_last, 128 + rl);
        chk({tag, " bv_cnt"}, bv_cnt, 128);
        chk({tag, " wr_first"}, wr_first, 1 + rl + bl);
        chk({tag, " wr_last"}, wr_last, 128 + rl + bl);
        chk({tag, " wr_cnt"}, wr_cnt, 128);
        chk({tag, " done_cyc"}, done_cyc, 129 + rl + bl);
        chk({tag, " busy_first"}, busy_first, 1);
        chk({tag, " busy_last"}, busy_last, 128 + rl + bl);
        chk({tag, " busy_cnt"}, busy_cnt, 128 + rl + bl);
        chk({tag, " wr dup"}, dup, 0);
        chk({tag, " wr coverage"}, covered, 256);
        chk({tag, " ct_mode stable"}, mode_err, 0);
        foreach (tab[i]) begin
            if (tab[i].ct == mode && tab[i].layer == lay) begin
                chk($sformatf("%s k=%0d a", tag, tab[i].k), ra[tab[i].k], tab[i].a);
                chk($sformatf("%s k=%0d b", tag, tab[i].k), rb[tab[i].k], tab[i].b);
                chk($sformatf("%s k=%0d tw", tag, tab[i].k), rt[tab[i].k], tab[i].tw);
            end
        end
    endtask

    initial begin
        int n;
        tab.push_back('{1'b1, 3'd0, 0, 8'd0, 8'd128, 7'd1});
        tab.push_back('{1'b1, 3'd0, 37, 8'd37, 8'd165, 7'd1});
        tab.push_back('{1'b1, 3'd0, 127, 8'd127, 8'd255, 7'd1});
        tab.push_back('{1'b1, 3'd6, 0, 8'd0, 8'd2, 7'd64});
        tab.push_back('{1'b1, 3'd6, 1, 8'd1, 8'd3, 7'd64});
        tab.push_back('{1'b1, 3'd6, 2, 8'd4, 8'd6, 7'd65});
        tab.push_back('{1'b1, 3'd6, 127, 8'd253, 8'd255, 7'd127});
        tab.push_back('{1'b0, 3'd0, 0, 8'd0, 8'd2, 7'd127});
        tab.push_back('{1'b0, 3'd0, 3, 8'd5, 8'd7, 7'd126});
        tab.push_back('{1'b0, 3'd0, 127, 8'd253, 8'd255, 7'd64});
        tab.push_back('{1'b0, 3'd6, 0, 8'd0, 8'd128, 7'd1});
        tab.push_back('{1'b0, 3'd6, 5, 8'd5, 8'd133, 7'd1});
        tab.push_back('{1'b0, 3'd6, 127, 8'd127, 8'd255, 7'd1});
        tab.push_back('{1'b1, 3'd3, 20, 8'd36, 8'd52, 7'd9});
        tab.push_back('{1'b1, 3'd3, 127, 8'd239, 8'd255, 7'd15});
        tab.push_back('{1'b0, 3'd2, 10, 8'd18, 8'd26, 7'd30});
        tab.push_back('{1'b0, 3'd2, 127, 8'd247, 8'd255, 7'd16});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs dut", {busy, done, ct_mode, rd_en, rd_addr_a, rd_addr_b, tw_addr,
            bf_valid, wr_en, wr_addr_a, wr_addr_b}, 0);
        chk("reset outputs dut2", {busy2, done2, ct_mode2, rd_en2, rd_addr_a2, rd_addr_b2, tw_addr2,
            bf_valid2, wr_en2, wr_addr_a2, wr_addr_b2}, 0);
        rst = 1'b0;

        run(1'b0, 1'b1, 3'd0, -5, "ct0");
        chk("ct0 first wr a", wa0, 0);
        chk("ct0 first wr b", wb0, 128);
        run(1'b0, 1'b1, 3'd6, -5, "ct6");
        run(1'b0, 1'b0, 3'd0, -5, "gs0");
        run(1'b0, 1'b0, 3'd6, -5, "gs6 back-to-back");

        sel = 1'b0;
        @(negedge clk);
        ct = 1'b1;
        layer = 3'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || rd_en || done) n++;
        end
        chk("layer7 ignored", n, 0);

        run(1'b0, 1'b0, 3'd2, 40, "gs2 mid-run start");

        @(negedge clk);
        ct = 1'b1;
        layer = 3'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("pre-reset rd_en", rd_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-run reset outputs", {busy, done, ct_mode, rd_en, rd_addr_a, rd_addr_b, tw_addr,
            bf_valid, wr_en, wr_addr_a, wr_addr_b}, 0);
        rst = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || wr_en || done) n++;
        end
        chk("after reset quiet", n, 0);
        run(1'b0, 1'b1, 3'd3, -5, "ct3 after reset");

        run(1'b1, 1'b1, 3'd0, -5, "sweep ct0");
        chk("sweep first wr a", wa0, 0);
        chk("sweep first wr b", wb0, 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ntt_layer_sequencer.md
Name: ntt_layer_sequencer

Overview:
- Upstream/downstream controller for the Kyber butterfly unit; runs one complete NTT (CT) or inverse-NTT (GS) layer over a 256-coefficient polynomial.
- Issues 128 coefficient-pair read addresses and twiddle ROM indices, one per cycle.
- Drives butterfly mode and input-valid.
- Delays the address pair through a pipeline matched to memory and butterfly latency, then asserts write-back of the butterfly E/O outputs.

Parameters:
- RD_LAT, 1, read latency of the coefficient RAM and twiddle ROM, in cycles (>=1).
- BF_LAT, 4, butterfly latency from A/B/W valid to E/O valid, in cycles (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- ct  in  1  1 = CT forward layer, 0 = GS inverse layer; sampled with start.
- layer  in  3  layer index 0..6; sampled with start.
- busy  out  1  high while a layer is in progress.
- done  out  1  one-cycle pulse after the last write.
- ct_mode  out  1  registered mode to the butterfly CT input; held stable during busy.
- rd_en  out  1  read strobe for RAM and ROM.
- rd_addr_a  out  8  address of the even-side coefficient (butterfly A).
- rd_addr_b  out  8  address of the odd-side coefficient (butterfly B).
- tw_addr  out  7  twiddle ROM index (butterfly W).
- bf_valid  out  1  butterfly A/B/W valid; equals rd_en delayed RD_LAT.
- wr_en  out  1  write strobe for E/O results.
- wr_addr_a  out  8  write address for E.
- wr_addr_b  out  8  write address for O.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset forces IDLE, clears the k counter, and clears every output register and delay stage to 0.
  - In-flight writes are dropped; no done pulse is produced.
  - This holds for reset at any point, including mid-layer.
- FSM states and transitions:
  - IDLE -> ISSUE when start=1 and layer<=6. start with layer=7 is ignored: no busy, no done.
  - ISSUE -> DRAIN after k=127 is issued.
  - DRAIN -> DONE when the last delayed write has been emitted.
  - DONE -> IDLE unconditionally after one cycle.
- ct and layer are latched on start.
  - start while busy is ignored.
  - Input changes during busy have no effect.
- Address generation, with 7-bit counter k = 0..127 incremented each ISSUE cycle:
  - CT: s = 7-layer. GS: s = layer+1. len = 1<<s.
  - off = k & (len-1); grp = k >> s.
  - rd_addr_a = (grp << (s+1)) | off; rd_addr_b = rd_addr_a + len.
  - CT: tw_addr = (1<<layer) + grp.
  - GS: tw_addr = (128>>layer) - 1 - grp.
- Timing:
  - start high in cycle 0 -> rd_en high in cycles 1..128.
  - bf_valid = rd_en delayed RD_LAT.
  - wr_en and wr addresses = rd_en and rd addresses delayed RD_LAT+BF_LAT.
- busy: high from the first ISSUE cycle through the last wr_en cycle; low during DONE and IDLE.
- done: single-cycle pulse in the cycle after the last wr_en.
- Addresses are don't-care when their strobe is low, but must be registered. No combinational path from inputs to outputs.
- Throughput: one butterfly per cycle; no bubbles within a layer.
- Back-to-back layers: a new start is accepted the cycle after done returns the FSM to IDLE.

Decomposition:
- Package ntt_pkg:
  - N=256, NUM_BF=128, ADDR_W=8, TW_W=7, LAYER_W=3, MAX_LAYER=6.
  - Mode constants MODE_GS=0, MODE_CT=1.
- Sub-module ntt_delay_line, parameterised (DEPTH, WIDTH), with synchronous reset to 0:
  - Instance 1: {rd_en, rd_addr_a, rd_addr_b} delayed BF_LAT+RD_LAT.
  - Instance 2: rd_en delayed RD_LAT for bf_valid.

Test Plan:
- CT layer 0, defaults, start at cycle 0 -> rd_en cycles 1..128; first issue a=0, b=128, tw=1; last issue a=127, b=255, tw=1; wr_en cycles 6..133 with a=0/b=128 at cycle 6; done at 134; busy 1..133.
- CT layer 6 -> k=0: a=0, b=2, tw=64; k=1: a=1, b=3, tw=64; k=2: a=4, b=6, tw=65; k=127: a=253, b=255, tw=127.
- GS layer 0 then GS layer 6 back-to-back:
  - Layer 0: k=0 a=0, b=2, tw=127; k=127 a=253, b=255, tw=64.
  - Layer 6: tw=1 for all k; k=5 gives a=5, b=133.
  - ct_mode=0 throughout.
- Reset at cycle 50 of a CT layer-3 run -> next cycle all outputs 0, no done, no further wr_en; a fresh start then produces a full 128-write run.
- start pulsed mid-run with a different layer, and start with layer=7 in IDLE -> both ignored; addresses unchanged; layer=7 yields no busy.
- Parameter sweep RD_LAT=2, BF_LAT=6 -> bf_valid cycles 3..130; wr_en cycles 9..136; done at 137; every write address pair is a permutation covering 0..255 exactly once per layer.
